// File: rtl/synth_mixer_seq_if.sv
// Sample-set handshake and mixed-output bundle between the voice bank and synth_mixer_seq.
// master drives the channel samples; slave is the mixer.
interface synth_mixer_seq_if #(
  parameter int DATA_BITS    = 12,
  parameter int NUM_CHANNELS = 12,
  parameter int GAIN_BITS    = 8
);
  logic [NUM_CHANNELS*DATA_BITS-1:0] din;
  logic [NUM_CHANNELS*GAIN_BITS-1:0] gain;
  logic [NUM_CHANNELS-1:0]           ch_en;
  logic                              in_valid;
  logic                              busy;
  logic [DATA_BITS-1:0]              dout;
  logic                              dout_valid;
  logic                              clip;
  logic                              overrun;

  modport master (
    output din, gain, ch_en, in_valid,
    input  busy, dout, dout_valid, clip, overrun
  );

  modport slave (
    input  din, gain, ch_en, in_valid,
    output busy, dout, dout_valid, clip, overrun
  );
endinterface

// File: rtl/synth_mixer_seq.sv
// Time-multiplexed N-channel mixer: snapshot, accumulate one channel per clock, normalise, saturate.
// Define SYNTH_MIXER_GAIN_EN to build the per-channel gain multiply; otherwise every term is unity gain.
//
// state | meaning
// IDLE  | waiting for in_valid; latches din/gain/ch_en on the strobe
// ACCUM | adds one latched channel term per cycle, idx 0..NUM_CHANNELS-1
// NORM  | divides by 2**ceil(log2(n_enabled)), saturates, registers dout
module synth_mixer_seq #(
  parameter int DATA_BITS    = 12,
  parameter int NUM_CHANNELS = 12,
  parameter int GAIN_BITS    = 8
) (
  input logic              clk,
  input logic              rst,
  synth_mixer_seq_if.slave bus
);
  localparam int IDX_W     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int CNT_W     = $clog2(NUM_CHANNELS + 1);
  localparam int TERM_BITS = DATA_BITS + 1;
  localparam int ACC_BITS  = DATA_BITS + 1 + $clog2(NUM_CHANNELS) + 1;
  localparam logic [IDX_W-1:0]           LAST_IDX = IDX_W'(NUM_CHANNELS - 1);
  localparam logic signed [ACC_BITS-1:0] SAT_MAX  = ACC_BITS'((1 << (DATA_BITS - 1)) - 1);
  localparam logic signed [ACC_BITS-1:0] SAT_MIN  = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, ACCUM, NORM} state_t;
  state_t state, state_n;

  logic [NUM_CHANNELS*DATA_BITS-1:0] din_q;
  logic [NUM_CHANNELS-1:0]           en_q;
  logic [IDX_W-1:0]                  idx;
  logic signed [ACC_BITS-1:0]        acc;
  logic signed [DATA_BITS-1:0]       dout_q;
  logic                              dout_valid_q;
  logic                              clip_q;
  logic                              overrun_q;

  logic load, step, finish;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          load    = 1'b1;
          state_n = ACCUM;
        end
      end
      ACCUM: begin
        step = 1'b1;
        if (idx == LAST_IDX) state_n = NORM;
      end
      NORM: begin
        finish  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  logic signed [DATA_BITS-1:0] cur_din;
  logic signed [TERM_BITS-1:0] term;
  logic signed [ACC_BITS-1:0]  term_ext;

  assign cur_din = din_q[int'(idx)*DATA_BITS +: DATA_BITS];

`ifdef SYNTH_MIXER_GAIN_EN
  logic [NUM_CHANNELS*GAIN_BITS-1:0]   gain_q;
  logic signed [GAIN_BITS:0]           cur_gain;
  logic signed [DATA_BITS+GAIN_BITS:0] prod;
  logic signed [DATA_BITS+GAIN_BITS:0] prod_sh;
  logic                                unused_prod_hi;

  always_ff @(posedge clk) begin
    if (rst)       gain_q <= '0;
    else if (load) gain_q <= bus.gain;
  end

  // Zero-extended gain keeps 255 positive; >>> floors toward -inf.
  assign cur_gain       = {1'b0, gain_q[int'(idx)*GAIN_BITS +: GAIN_BITS]};
  assign prod           = cur_din * cur_gain;
  assign prod_sh        = prod >>> (GAIN_BITS - 1);
  assign term           = prod_sh[TERM_BITS-1:0];
  assign unused_prod_hi = ^prod_sh[DATA_BITS+GAIN_BITS:TERM_BITS];
`else
  logic unused_gain;
  assign unused_gain = ^bus.gain;
  assign term        = {cur_din[DATA_BITS-1], cur_din};
`endif

  assign term_ext = en_q[idx] ? {{(ACC_BITS-TERM_BITS){term[TERM_BITS-1]}}, term} : '0;

  logic [CNT_W-1:0]            n_en;
  logic [CNT_W-1:0]            sh;
  logic signed [ACC_BITS-1:0]  acc_sh;
  logic signed [DATA_BITS-1:0] res;
  logic                        sat;

  // sh = ceil(log2(n_en)): count of powers of two strictly below n_en.
  always_comb begin
    n_en = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) n_en = n_en + CNT_W'(en_q[i]);
    sh = '0;
    for (int k = 0; k < CNT_W; k++) begin
      if (int'(n_en) > (1 << k)) sh = sh + CNT_W'(1);
    end
    acc_sh = acc >>> sh;
    res    = '0;
    sat    = 1'b0;
    if (n_en == '0) begin
      res = '0;
    end else if (acc_sh > SAT_MAX) begin
      res = SAT_MAX[DATA_BITS-1:0];
      sat = 1'b1;
    end else if (acc_sh < SAT_MIN) begin
      res = SAT_MIN[DATA_BITS-1:0];
      sat = 1'b1;
    end else begin
      res = acc_sh[DATA_BITS-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      din_q        <= '0;
      en_q         <= '0;
      idx          <= '0;
      acc          <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      clip_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      dout_valid_q <= finish;
      clip_q       <= finish & sat;
      overrun_q    <= bus.in_valid && (state != IDLE);
      if (load) begin
        din_q <= bus.din;
        en_q  <= bus.ch_en;
        acc   <= '0;
        idx   <= '0;
      end else if (step) begin
        acc <= acc + term_ext;
        idx <= idx + IDX_W'(1);
      end
      if (finish) dout_q <= res;
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.clip       = clip_q;
  assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_synth_mixer_seq.sv
// Scoreboard bench for synth_mixer_seq (12-bit samples, 4 channels, 8-bit gain).
// Expectations follow whichever build SYNTH_MIXER_GAIN_EN selects.
module tb_synth_mixer_seq;
  localparam int DB = 12;
  localparam int NC = 4;
  localparam int GB = 8;
  localparam int LAT = NC + 2;

  logic clk;
  logic rst;
  int   cyc;
  int   errors;
  int   checks;

  synth_mixer_seq_if #(.DATA_BITS(DB), .NUM_CHANNELS(NC), .GAIN_BITS(GB)) bus();

  synth_mixer_seq #(.DATA_BITS(DB), .NUM_CHANNELS(NC), .GAIN_BITS(GB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int d;
    int c;
    int due;
  } exp_t;

  exp_t q[$];
  int   ov_q[$];

`ifdef SYNTH_MIXER_GAIN_EN
  localparam int GAIN_ON = 1;
`else
  localparam int GAIN_ON = 0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per presented output.
  always @(negedge clk) begin
    if (!rst && bus.dout_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_dout_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("dout", int'($signed(bus.dout)), e.d);
        chk("clip", int'(bus.clip), e.c);
        chk("latency_cycle", cyc, e.due);
        chk("busy_at_valid", int'(bus.busy), 0);
      end
    end
    if (!rst && bus.overrun) begin
      if (ov_q.size() == 0) chk("unexpected_overrun", 1, 0);
      else                  chk("overrun_cycle", cyc, ov_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int c0, input int c1, input int c2, input int c3,
                       input int g, input logic [NC-1:0] en);
    bus.din      = {12'(c3), 12'(c2), 12'(c1), 12'(c0)};
    bus.gain     = {NC{8'(g)}};
    bus.ch_en    = en;
    bus.in_valid = 1'b1;
  endtask

  // Scramble inputs after the strobe so only the latched copy can give the right answer.
  task automatic release_inputs();
    bus.in_valid = 1'b0;
    bus.din      = ~bus.din;
    bus.gain     = ~bus.gain;
    bus.ch_en    = ~bus.ch_en;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0) break;
      step();
    end
    chk("drain_pending", q.size(), 0);
  endtask

  task automatic mix(input int c0, input int c1, input int c2, input int c3,
                     input int g, input logic [NC-1:0] en, input int d, input int c);
    step();
    drive(c0, c1, c2, c3, g, en);
    q.push_back('{d: d, c: c, due: cyc + LAT});
    step();
    release_inputs();
    drain();
  endtask

  initial begin
    cyc          = 0;
    errors       = 0;
    checks       = 0;
    rst          = 1'b1;
    bus.din      = '0;
    bus.gain     = '0;
    bus.ch_en    = '0;
    bus.in_valid = 1'b0;
    repeat (3) step();

    chk("rst_dout", int'(bus.dout), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_dout_valid", int'(bus.dout_valid), 0);
    chk("rst_clip", int'(bus.clip), 0);
    chk("rst_overrun", int'(bus.overrun), 0);
    rst = 1'b0;

    mix(100, 300, 999, -999, 128, 4'b0011, 200, 0);
    mix(2047, 2047, 2047, 2047, 128, 4'b1111, 2047, 0);
    mix(2047, 2047, 2047, 2047, 255, 4'b0011, 2047, GAIN_ON);
    mix(-2048, -2048, 7, 7, 255, 4'b0011, -2048, GAIN_ON);
    mix(50, 60, 70, 80, 128, 4'b0000, 0, 0);
    mix(9, 9, -5, 9, 128, 4'b0100, -5, 0);
    mix(300, 300, 300, -2000, 128, 4'b0111, 225, 0);
    mix(-3, 0, 0, 0, 128, 4'b0011, -2, 0);
    mix(-3, 5, 5, 5, 64, 4'b0001, (GAIN_ON != 0) ? -2 : -3, 0);

    // Second strobe while busy is ignored; strobe after dout_valid is accepted.
    step();
    drive(100, 300, 0, 0, 128, 4'b0011);
    q.push_back('{d: 200, c: 0, due: cyc + LAT});
    step();
    release_inputs();
    step();
    step();
    drive(1000, 1000, 1000, 1000, 128, 4'b1111);
    ov_q.push_back(cyc + 1);
    step();
    release_inputs();
    step();
    step();
    step();
    drive(10, 20, 30, 40, 128, 4'b1111);
    q.push_back('{d: 25, c: 0, due: cyc + LAT});
    step();
    release_inputs();
    drain();
    chk("overrun_pending", ov_q.size(), 0);

    // Reset three cycles into a mix abandons it.
    step();
    drive(500, 500, 500, 500, 128, 4'b1111);
    step();
    release_inputs();
    step();
    step();
    rst = 1'b1;
    step();
    chk("midrst_dout", int'(bus.dout), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    rst = 1'b0;
    repeat (8) step();
    mix(-100, -300, 0, 0, 128, 4'b0011, -200, 0);

    // Reset wins over a same-cycle strobe.
    step();
    drive(1, 2, 3, 4, 128, 4'b1111);
    rst = 1'b1;
    step();
    rst = 1'b0;
    release_inputs();
    chk("rst_wins_busy", int'(bus.busy), 0);
    repeat (8) step();
    chk("final_pending", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
